axi_mem_arbiter: RTL and testbench

Two-master AXI4-lite arbiter sharing the single test memory slave between the instruction-fetch master (m0) and a second requester (m1, e.g. DMA or debug port). Serialises transactions: exactly one read or write outstanding at the slave. Grants round-robin or fixed priority, holds the grant until the response handshake, then re-arbitrates. Sits between the masters and the AXI4-lite memory model, with no address decoding.

---
 rtl/axi_mem_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_axi_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_arbiter.sv
// Two-master AXI4-lite arbiter in front of a single memory slave.
// One transaction is outstanding at the slave at a time. The owner is picked
// in IDLE (round-robin or fixed priority), kept until the response
// handshake, then the arbiter returns to IDLE for the next decision.
module axi_mem_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter bit WRITE_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  // master 0
  input  logic        m0_axi_awvalid,
  output logic        m0_axi_awready,
  input  logic [31:0] m0_axi_awaddr,
  input  logic [2:0]  m0_axi_awprot,
  input  logic        m0_axi_wvalid,
  output logic        m0_axi_wready,
  input  logic [31:0] m0_axi_wdata,
  input  logic [3:0]  m0_axi_wstrb,
  output logic        m0_axi_bvalid,
  input  logic        m0_axi_bready,
  input  logic        m0_axi_arvalid,
  output logic        m0_axi_arready,
  input  logic [31:0] m0_axi_araddr,
  input  logic [2:0]  m0_axi_arprot,
  output logic        m0_axi_rvalid,
  input  logic        m0_axi_rready,
  output logic [31:0] m0_axi_rdata,
  // master 1
  input  logic        m1_axi_awvalid,
  output logic        m1_axi_awready,
  input  logic [31:0] m1_axi_awaddr,
  input  logic [2:0]  m1_axi_awprot,
  input  logic        m1_axi_wvalid,
  output logic        m1_axi_wready,
  input  logic [31:0] m1_axi_wdata,
  input  logic [3:0]  m1_axi_wstrb,
  output logic        m1_axi_bvalid,
  input  logic        m1_axi_bready,
  input  logic        m1_axi_arvalid,
  output logic        m1_axi_arready,
  input  logic [31:0] m1_axi_araddr,
  input  logic [2:0]  m1_axi_arprot,
  output logic        m1_axi_rvalid,
  input  logic        m1_axi_rready,
  output logic [31:0] m1_axi_rdata,
  // slave (memory) side
  output logic        s_axi_awvalid,
  input  logic        s_axi_awready,
  output logic [31:0] s_axi_awaddr,
  output logic [2:0]  s_axi_awprot,
  output logic        s_axi_wvalid,
  input  logic        s_axi_wready,
  output logic [31:0] s_axi_wdata,
  output logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_bvalid,
  output logic        s_axi_bready,
  output logic        s_axi_arvalid,
  input  logic        s_axi_arready,
  output logic [31:0] s_axi_araddr,
  output logic [2:0]  s_axi_arprot,
  input  logic        s_axi_rvalid,
  output logic        s_axi_rready,
  input  logic [31:0] s_axi_rdata,
  // status
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_RESP, WR_XFER, WR_RESP} state_t;

  state_t state, state_nxt;
  logic   gnt;          // owner of the current transaction: 0 = m0, 1 = m1
  logic   last_grant;   // owner of the previous decision, for round-robin
  logic   aw_done, w_done;
  logic   req0, req1, win, win_wr;
  logic   aw_hs, w_hs;
  logic   rt_awready, rt_wready, rt_bvalid, rt_arready, rt_rvalid;

  // Selected master's request-side signals
  logic        sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
  logic [31:0] sel_awaddr, sel_wdata, sel_araddr;
  logic [2:0]  sel_awprot, sel_arprot;
  logic [3:0]  sel_wstrb;

  assign sel_awvalid = gnt ? m1_axi_awvalid : m0_axi_awvalid;
  assign sel_awaddr  = gnt ? m1_axi_awaddr  : m0_axi_awaddr;
  assign sel_awprot  = gnt ? m1_axi_awprot  : m0_axi_awprot;
  assign sel_wvalid  = gnt ? m1_axi_wvalid  : m0_axi_wvalid;
  assign sel_wdata   = gnt ? m1_axi_wdata   : m0_axi_wdata;
  assign sel_wstrb   = gnt ? m1_axi_wstrb   : m0_axi_wstrb;
  assign sel_bready  = gnt ? m1_axi_bready  : m0_axi_bready;
  assign sel_arvalid = gnt ? m1_axi_arvalid : m0_axi_arvalid;
  assign sel_araddr  = gnt ? m1_axi_araddr  : m0_axi_araddr;
  assign sel_arprot  = gnt ? m1_axi_arprot  : m0_axi_arprot;
  assign sel_rready  = gnt ? m1_axi_rready  : m0_axi_rready;

  // Arbitration: a write needs only awvalid; wvalid may follow later.
  assign req0   = m0_axi_arvalid | m0_axi_awvalid;
  assign req1   = m1_axi_arvalid | m1_axi_awvalid;
  assign win    = (req0 && req1) ? (ROUND_ROBIN ? ~last_grant : 1'b0) : req1;
  assign win_wr = win ? (m1_axi_awvalid && (WRITE_FIRST || !m1_axi_arvalid))
                      : (m0_axi_awvalid && (WRITE_FIRST || !m0_axi_arvalid));

  // Next-state decode and combinational routing between owner and slave
  always_comb begin
    state_nxt     = state;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    s_axi_awvalid = 1'b0;
    s_axi_awaddr  = '0;
    s_axi_awprot  = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_bready  = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arprot  = '0;
    s_axi_rready  = 1'b0;
    rt_awready    = 1'b0;
    rt_wready     = 1'b0;
    rt_bvalid     = 1'b0;
    rt_arready    = 1'b0;
    rt_rvalid     = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) state_nxt = win_wr ? WR_XFER : RD_ADDR;
      end
      RD_ADDR: begin
        s_axi_arvalid = sel_arvalid;
        s_axi_araddr  = sel_araddr;
        s_axi_arprot  = sel_arprot;
        rt_arready    = s_axi_arready;
        if (sel_arvalid && s_axi_arready) state_nxt = RD_RESP;
      end
      RD_RESP: begin
        s_axi_araddr = sel_araddr;
        s_axi_arprot = sel_arprot;
        s_axi_rready = sel_rready;
        rt_rvalid    = s_axi_rvalid;
        if (s_axi_rvalid && sel_rready) state_nxt = IDLE;
      end
      WR_XFER: begin
        s_axi_awaddr  = sel_awaddr;
        s_axi_awprot  = sel_awprot;
        s_axi_wdata   = sel_wdata;
        s_axi_wstrb   = sel_wstrb;
        // a channel that already handshook is masked so it cannot fire twice
        s_axi_awvalid = sel_awvalid & ~aw_done;
        s_axi_wvalid  = sel_wvalid & ~w_done;
        rt_awready    = s_axi_awready & ~aw_done;
        rt_wready     = s_axi_wready & ~w_done;
        aw_hs         = s_axi_awvalid & s_axi_awready;
        w_hs          = s_axi_wvalid & s_axi_wready;
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        s_axi_awaddr = sel_awaddr;
        s_axi_awprot = sel_awprot;
        s_axi_wdata  = sel_wdata;
        s_axi_wstrb  = sel_wstrb;
        s_axi_bready = sel_bready;
        rt_bvalid    = s_axi_bvalid;
        if (s_axi_bvalid && sel_bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy  = (state != IDLE);
  assign grant = busy ? (gnt ? 2'b10 : 2'b01) : 2'b00;

  // Only the owner sees readies/valids; the other master is held off
  assign m0_axi_awready = grant[0] & rt_awready;
  assign m0_axi_wready  = grant[0] & rt_wready;
  assign m0_axi_bvalid  = grant[0] & rt_bvalid;
  assign m0_axi_arready = grant[0] & rt_arready;
  assign m0_axi_rvalid  = grant[0] & rt_rvalid;
  assign m0_axi_rdata   = grant[0] ? s_axi_rdata : '0;
  assign m1_axi_awready = grant[1] & rt_awready;
  assign m1_axi_wready  = grant[1] & rt_wready;
  assign m1_axi_bvalid  = grant[1] & rt_bvalid;
  assign m1_axi_arready = grant[1] & rt_arready;
  assign m1_axi_rvalid  = grant[1] & rt_rvalid;
  assign m1_axi_rdata   = grant[1] ? s_axi_rdata : '0;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Owner capture, round-robin history and sticky write-channel flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt        <= 1'b0;
      last_grant <= 1'b1;   // so m0 wins the first tie
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      if (state == IDLE && (req0 || req1)) begin
        gnt        <= win;
        last_grant <= win;
      end
      if (state == WR_XFER) begin
        if (state_nxt == WR_RESP) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          aw_done <= aw_done | aw_hs;
          w_done  <= w_done | w_hs;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Bench for axi_mem_arbiter: instance 0 is round-robin, instance 1 fixed
// priority. Both share the master stimulus; each has its own memory model.
module tb_axi_mem_arbiter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // shared master-side stimulus
  logic        m0_awvalid, m0_wvalid, m0_bready, m0_arvalid, m0_rready;
  logic [31:0] m0_awaddr, m0_wdata, m0_araddr;
  logic [2:0]  m0_awprot, m0_arprot;
  logic [3:0]  m0_wstrb;
  logic        m1_awvalid, m1_wvalid, m1_bready, m1_arvalid, m1_rready;
  logic [31:0] m1_awaddr, m1_wdata, m1_araddr;
  logic [2:0]  m1_awprot, m1_arprot;
  logic [3:0]  m1_wstrb;

  function automatic logic [31:0] mem_init(input int i);
    return (i == 4) ? 32'h1234_5678 : (32'hA500_0000 | 32'(i));
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid;
    logic [31:0] m1_rdata;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [2:0]  s_awprot, s_arprot;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        busy;
    logic [31:0] mem [256];
    logic        aw_got, w_got;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ws;

    axi_mem_arbiter #(.ROUND_ROBIN(g == 0), .WRITE_FIRST(1'b1)) u_dut (
      .clk(clk), .resetn(resetn),
      .m0_axi_awvalid(m0_awvalid), .m0_axi_awready(m0_awready), .m0_axi_awaddr(m0_awaddr), .m0_axi_awprot(m0_awprot),
      .m0_axi_wvalid(m0_wvalid), .m0_axi_wready(m0_wready), .m0_axi_wdata(m0_wdata), .m0_axi_wstrb(m0_wstrb),
      .m0_axi_bvalid(m0_bvalid), .m0_axi_bready(m0_bready),
      .m0_axi_arvalid(m0_arvalid), .m0_axi_arready(m0_arready), .m0_axi_araddr(m0_araddr), .m0_axi_arprot(m0_arprot),
      .m0_axi_rvalid(m0_rvalid), .m0_axi_rready(m0_rready), .m0_axi_rdata(m0_rdata),
      .m1_axi_awvalid(m1_awvalid), .m1_axi_awready(m1_awready), .m1_axi_awaddr(m1_awaddr), .m1_axi_awprot(m1_awprot),
      .m1_axi_wvalid(m1_wvalid), .m1_axi_wready(m1_wready), .m1_axi_wdata(m1_wdata), .m1_axi_wstrb(m1_wstrb),
      .m1_axi_bvalid(m1_bvalid), .m1_axi_bready(m1_bready),
      .m1_axi_arvalid(m1_arvalid), .m1_axi_arready(m1_arready), .m1_axi_araddr(m1_araddr), .m1_axi_arprot(m1_arprot),
      .m1_axi_rvalid(m1_rvalid), .m1_axi_rready(m1_rready), .m1_axi_rdata(m1_rdata),
      .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready), .s_axi_awaddr(s_awaddr), .s_axi_awprot(s_awprot),
      .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready), .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb),
      .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
      .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready), .s_axi_araddr(s_araddr), .s_axi_arprot(s_arprot),
      .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready), .s_axi_rdata(s_rdata),
      .grant(grant), .busy(busy)
    );

    // zero-wait memory slave: read data one cycle after ar, b after aw+w
    assign s_awready = ~aw_got & ~s_bvalid;
    assign s_wready  = ~w_got & ~s_bvalid;
    assign s_arready = ~s_rvalid;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
        aw_got <= 1'b0; w_got <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0;
        s_rdata <= '0; wa <= '0; wd <= '0; ws <= '0;
      end else begin
        if (s_arvalid && s_arready) begin
          s_rvalid <= 1'b1;
          s_rdata  <= mem[s_araddr[9:2]];
        end else if (s_rvalid && s_rready) begin
          s_rvalid <= 1'b0;
        end
        if (aw_got && w_got) begin
          for (int b = 0; b < 4; b++)
            if (ws[b]) mem[wa][8*b +: 8] <= wd[8*b +: 8];
          s_bvalid <= 1'b1;
          aw_got   <= 1'b0;
          w_got    <= 1'b0;
        end else begin
          if (s_awvalid && s_awready) begin aw_got <= 1'b1; wa <= s_awaddr[9:2]; end
          if (s_wvalid && s_wready) begin w_got <= 1'b1; wd <= s_wdata; ws <= s_wstrb; end
        end
        if (s_bvalid && s_bready) s_bvalid <= 1'b0;
      end
    end
  end

  typedef struct {
    logic        wr;
    logic        mst;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl [256];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input logic wr, input logic mst, input logic [31:0] data);
    exp_t e;
    if (sbq.size() == 0) begin
      check("sb_unexpected_response", 64'(sbq.size()), 64'd1);
    end else begin
      e = sbq.pop_front();
      check("sb_dir", 64'(wr), 64'(e.wr));
      check("sb_master", 64'(mst), 64'(e.mst));
      if (!e.wr) check("sb_rdata", 64'(data), 64'(e.data));
    end
  endtask

  // Drive masters like well-behaved AXI sources on instance 0 and retire
  // responses against the scoreboard until it is empty or time runs out.
  task automatic service(input int max_cyc);
    logic d_aw0, d_w0, d_ar0, d_aw1, d_w1, d_ar1;
    for (int n = 0; n < max_cyc && sbq.size() > 0; n++) begin
      @(negedge clk);
      d_aw0 = m0_awvalid & g_dut[0].m0_awready;
      d_w0  = m0_wvalid  & g_dut[0].m0_wready;
      d_ar0 = m0_arvalid & g_dut[0].m0_arready;
      d_aw1 = m1_awvalid & g_dut[0].m1_awready;
      d_w1  = m1_wvalid  & g_dut[0].m1_wready;
      d_ar1 = m1_arvalid & g_dut[0].m1_arready;
      if (g_dut[0].m0_bvalid || g_dut[0].m1_bvalid)
        check("b_exclusive", 64'(g_dut[0].m0_bvalid & g_dut[0].m1_bvalid), 64'd0);
      if (g_dut[0].m0_rvalid || g_dut[0].m1_rvalid)
        check("r_exclusive", 64'(g_dut[0].m0_rvalid & g_dut[0].m1_rvalid), 64'd0);
      if (g_dut[0].m0_bvalid && m0_bready) sb_pop(1'b1, 1'b0, 32'h0);
      if (g_dut[0].m1_bvalid && m1_bready) sb_pop(1'b1, 1'b1, 32'h0);
      if (g_dut[0].m0_rvalid && m0_rready) sb_pop(1'b0, 1'b0, g_dut[0].m0_rdata);
      if (g_dut[0].m1_rvalid && m1_rready) sb_pop(1'b0, 1'b1, g_dut[0].m1_rdata);
      @(posedge clk); #1;
      if (d_aw0) m0_awvalid = 1'b0;
      if (d_w0)  m0_wvalid  = 1'b0;
      if (d_ar0) m0_arvalid = 1'b0;
      if (d_aw1) m1_awvalid = 1'b0;
      if (d_w1)  m1_wvalid  = 1'b0;
      if (d_ar1) m1_arvalid = 1'b0;
    end
    check("sb_drained", 64'(sbq.size()), 64'd0);
  endtask

  task automatic reset_assert();
    resetn = 1'b0;
    m0_awvalid = 0; m0_awaddr = '0; m0_awprot = '0; m0_wvalid = 0; m0_wdata = '0; m0_wstrb = '0;
    m0_bready = 0; m0_arvalid = 0; m0_araddr = '0; m0_arprot = '0; m0_rready = 0;
    m1_awvalid = 0; m1_awaddr = '0; m1_awprot = '0; m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0;
    m1_bready = 0; m1_arvalid = 0; m1_araddr = '0; m1_arprot = '0; m1_rready = 0;
    for (int i = 0; i < 256; i++) mdl[i] = mem_init(i);
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] exp_rr, exp_fp;

    // ---------------- reset state
    reset_assert();
    check("rst_grant", 64'(g_dut[0].grant), 64'd0);
    check("rst_busy", 64'(g_dut[0].busy), 64'd0);
    check("rst_slave_ctl", 64'({g_dut[0].s_awvalid, g_dut[0].s_wvalid, g_dut[0].s_bready,
                                g_dut[0].s_arvalid, g_dut[0].s_rready}), 64'd0);
    check("rst_slave_payload", {g_dut[0].s_awaddr, g_dut[0].s_araddr}, 64'd0);
    check("rst_master_ctl", 64'({g_dut[0].m0_awready, g_dut[0].m0_wready, g_dut[0].m0_bvalid,
                                 g_dut[0].m0_arready, g_dut[0].m0_rvalid, g_dut[0].m1_rvalid}), 64'd0);
    resetn = 1'b1;

    // ---------------- single read by m0
    @(posedge clk); #1;
    m0_arvalid = 1; m0_araddr = 32'h10; m0_arprot = 3'b010; m0_rready = 1;
    sbq.push_back('{1'b0, 1'b0, mdl[4]});
    @(negedge clk);
    check("rd_idle_grant", 64'(g_dut[0].grant), 64'd0);
    @(negedge clk);
    check("rd_grant", 64'(g_dut[0].grant), 64'b01);
    check("rd_busy", 64'(g_dut[0].busy), 64'd1);
    check("rd_s_arvalid", 64'(g_dut[0].s_arvalid), 64'd1);
    check("rd_s_araddr", 64'(g_dut[0].s_araddr), 64'h10);
    check("rd_s_arprot", 64'(g_dut[0].s_arprot), 64'd2);
    check("rd_m0_arready", 64'(g_dut[0].m0_arready), 64'd1);
    check("rd_m1_arready", 64'(g_dut[0].m1_arready), 64'd0);
    @(posedge clk); #1;
    m0_arvalid = 0;
    @(negedge clk);
    check("rd_m0_rvalid", 64'(g_dut[0].m0_rvalid), 64'd1);
    check("rd_m1_rvalid", 64'(g_dut[0].m1_rvalid), 64'd0);
    check("rd_m1_rdata", 64'(g_dut[0].m1_rdata), 64'd0);
    sb_pop(1'b0, 1'b0, g_dut[0].m0_rdata);
    @(negedge clk);
    check("rd_done_grant", 64'(g_dut[0].grant), 64'd0);
    check("rd_done_busy", 64'(g_dut[0].busy), 64'd0);

    // ---------------- contention: round robin (inst 0) and fixed (inst 1)
    reset_assert();
    m0_arvalid = 1; m0_araddr = 32'h20; m0_rready = 1;
    m1_arvalid = 1; m1_araddr = 32'h40; m1_rready = 1;
    for (int k = 0; k < 2; k++) begin
      sbq.push_back('{1'b0, 1'b0, mdl[8]});
      sbq.push_back('{1'b0, 1'b1, mdl[16]});
    end
    resetn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp_rr = (c % 3 == 2) ? 2'b00 : (((c / 3) % 2 == 1) ? 2'b10 : 2'b01);
      exp_fp = (c % 3 == 2) ? 2'b00 : 2'b01;
      check("rr_grant", 64'(g_dut[0].grant), 64'(exp_rr));
      check("fp_grant", 64'(g_dut[1].grant), 64'(exp_fp));
      if (g_dut[0].m0_rvalid) sb_pop(1'b0, 1'b0, g_dut[0].m0_rdata);
      if (g_dut[0].m1_rvalid) sb_pop(1'b0, 1'b1, g_dut[0].m1_rdata);
    end
    check("rr_drained", 64'(sbq.size()), 64'd0);

    // ---------------- skewed write by m1: w arrives 3 cycles after aw
    reset_assert();
    resetn = 1'b1;
    @(posedge clk); #1;
    m1_awvalid = 1; m1_awaddr = 32'h100; m1_awprot = 3'b001; m1_bready = 1;
    mdl[64] = (mdl[64] & 32'hFFFF_FF00) | 32'h0000_00FF;
    sbq.push_back('{1'b1, 1'b1, 32'h0});
    @(negedge clk);
    check("wr_idle_grant", 64'(g_dut[0].grant), 64'd0);
    @(negedge clk);
    check("wr_grant", 64'(g_dut[0].grant), 64'b10);
    check("wr_m1_awready", 64'(g_dut[0].m1_awready), 64'd1);
    check("wr_m0_awready", 64'(g_dut[0].m0_awready), 64'd0);
    check("wr_s_awaddr", 64'(g_dut[0].s_awaddr), 64'h100);
    check("wr_s_awprot", 64'(g_dut[0].s_awprot), 64'd1);
    check("wr_no_ar", 64'(g_dut[0].s_arvalid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("wr_aw_masked", 64'(g_dut[0].s_awvalid), 64'd0);
    check("wr_awready_masked", 64'(g_dut[0].m1_awready), 64'd0);
    check("wr_hold_grant", 64'(g_dut[0].grant), 64'b10);
    m1_awvalid = 0;
    @(posedge clk); #1;
    m1_wvalid = 1; m1_wdata = 32'h0000_00FF; m1_wstrb = 4'b0001;
    @(negedge clk);
    check("wr_still_xfer", 64'(g_dut[0].m1_bvalid), 64'd0);
    check("wr_m1_wready", 64'(g_dut[0].m1_wready), 64'd1);
    check("wr_s_wdata", {g_dut[0].s_wdata, 28'd0, g_dut[0].s_wstrb}, {32'h0000_00FF, 32'd1});
    @(posedge clk); #1;
    m1_wvalid = 0;
    service(10);
    // read back the partially written word through m0
    m0_arvalid = 1; m0_araddr = 32'h100; m0_rready = 1;
    sbq.push_back('{1'b0, 1'b0, mdl[64]});
    service(10);

    // ---------------- same master read and write, write goes first
    reset_assert();
    resetn = 1'b1;
    @(posedge clk); #1;
    m0_awvalid = 1; m0_awaddr = 32'h10; m0_wvalid = 1; m0_wdata = 32'hCAFE_F00D; m0_wstrb = 4'hF;
    m0_bready = 1; m0_arvalid = 1; m0_araddr = 32'h10; m0_rready = 1;
    mdl[4] = 32'hCAFE_F00D;
    sbq.push_back('{1'b1, 1'b0, 32'h0});
    sbq.push_back('{1'b0, 1'b0, mdl[4]});
    @(negedge clk);
    @(negedge clk);
    check("wf_dir", 64'({g_dut[0].s_awvalid, g_dut[0].s_arvalid}), 64'b10);
    @(posedge clk); #1;
    if (g_dut[0].busy) begin m0_awvalid = 0; m0_wvalid = 0; end
    service(30);

    // ---------------- reset during RD_RESP
    reset_assert();
    resetn = 1'b1;
    @(posedge clk); #1;
    m0_arvalid = 1; m0_araddr = 32'h10; m0_rready = 0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    m0_arvalid = 0;
    @(negedge clk);
    check("mid_busy", 64'(g_dut[0].busy), 64'd1);
    check("mid_rvalid", 64'(g_dut[0].m0_rvalid), 64'd1);
    resetn = 1'b0;
    #1;
    check("arst_grant", 64'(g_dut[0].grant), 64'd0);
    check("arst_busy", 64'(g_dut[0].busy), 64'd0);
    check("arst_valids", 64'({g_dut[0].m0_rvalid, g_dut[0].s_rready, g_dut[0].s_arvalid,
                              g_dut[0].m0_arready}), 64'd0);
    reset_assert();
    m0_arvalid = 1; m0_araddr = 32'h20; m0_rready = 1;
    m1_arvalid = 1; m1_araddr = 32'h40; m1_rready = 1;
    sbq.push_back('{1'b0, 1'b0, mdl[8]});
    sbq.push_back('{1'b0, 1'b1, mdl[16]});
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_tie", 64'(g_dut[0].grant), 64'b01);
    @(posedge clk); #1;
    m0_arvalid = 0;
    service(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
